sum_decomposer: RTL and testbench

Response-side inverse of the 8-bit adder: receives a 9-bit sum (carry included) with the known operand A, recovers operand B = sum − A, and flags sums that no 8-bit B can produce. It sits on the result path of the adder interface and feeds a downstream consumer through a valid/ready handshake. A one-stage compute register and a small FIFO provide back-pressure buffering, and saturating counters track transactions and range errors.

---
 rtl/sum_decomposer_if.sv | 50 +++++
 rtl/sum_decomposer.sv | 117 +++++++++++
 tb/tb_sum_decomposer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum_decomposer_if.sv
// ============================================================================
// Module   : sum_decomposer_if
// Purpose  : Result-path bundle for sum_decomposer (input handshake, output
//            handshake and counters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sum_decomposer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] operand_a;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] operand_b;
    logic             range_err;
    logic [15:0]      txn_count;
    logic [15:0]      err_count;

    modport master (
        output in_valid,
        output sum,
        output operand_a,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  operand_b,
        input  range_err,
        input  txn_count,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  sum,
        input  operand_a,
        input  out_ready,
        output in_ready,
        output out_valid,
        output operand_b,
        output range_err,
        output txn_count,
        output err_count
    );
endinterface

`default_nettype wire

// File: rtl/sum_decomposer.sv
// ============================================================================
// Module   : sum_decomposer
// Purpose  : Recovers B = sum - A from an adder result, flags unreachable sums,
//            buffers results through one compute stage and a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum_decomposer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sum_decomposer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef logic [WIDTH:0] entry_t;  // {range_err, operand_b}

    logic [WIDTH+1:0] diff;
    logic             diff_err;
    logic [OCC_W-1:0] occupancy;
    logic             accept;
    logic             push;
    logic             pop;
    logic             in_ready;
    logic             out_valid;

    logic             s1_valid_q, s1_valid_d;
    entry_t           s1_entry_q, s1_entry_d;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [15:0]      txn_count_q, txn_count_d;
    logic [15:0]      err_count_q, err_count_d;

    // Two extra bits: the top one is the sign, the next marks B >= 2^WIDTH.
    assign diff      = {1'b0, bus.sum} - {2'b00, bus.operand_a};
    assign diff_err  = |diff[WIDTH+1:WIDTH];

    // Occupancy counts the in-flight S1 entry so its FIFO slot is reserved.
    assign occupancy = {1'b0, fifo_count_q} + {{CNT_W{1'b0}}, s1_valid_q};
    assign in_ready  = occupancy < OCC_W'(DEPTH);
    assign out_valid = fifo_count_q != '0;
    assign accept    = bus.in_valid && in_ready;
    assign push      = s1_valid_q;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        s1_valid_d   = accept;
        s1_entry_d   = s1_entry_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        txn_count_d  = txn_count_q;
        err_count_d  = err_count_q;

        if (accept) begin
            s1_entry_d = {diff_err, diff[WIDTH-1:0]};
            if (txn_count_q != 16'hFFFF) txn_count_d = txn_count_q + 16'd1;
            if (diff_err && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
        end

        if (push) begin
            mem_d[wr_ptr_q] = s1_entry_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_entry_q   <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            txn_count_q  <= '0;
            err_count_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_entry_q   <= s1_entry_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            txn_count_q  <= txn_count_d;
            err_count_q  <= err_count_d;
        end
    end

    // Head data is forced to zero while the FIFO is empty.
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.operand_b = out_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
    assign bus.range_err = out_valid ? mem_q[rd_ptr_q][WIDTH] : 1'b0;
    assign bus.txn_count = txn_count_q;
    assign bus.err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_decomposer.sv
// ============================================================================
// Module   : tb_sum_decomposer
// Purpose  : Scoreboard bench for sum_decomposer against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_decomposer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] b;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_decomposer_if #(.WIDTH(WIDTH)) bus ();

    sum_decomposer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_txn  = 0;
    int   exp_err  = 0;
    int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer subtraction, B is the low byte when in range.
    function automatic exp_t model(input logic [8:0] s, input logic [7:0] a);
        exp_t r;
        int   d;
        d     = int'(s) - int'(a);
        r.err = (d < 0) || (d > 255);
        r.b   = d[7:0];
        return r;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    always @(negedge clk) begin
        case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: every pop is compared against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got b=%0h err=%0b, expected no output",
                             bus.operand_b, bus.range_err);
                end else begin
                    e = sb.pop_front();
                    check("operand_b", 32'(bus.operand_b), 32'(e.b));
                    check("range_err", 32'(bus.range_err), 32'(e.err));
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [8:0] s, input logic [7:0] a);
        bit done = 0;
        bus.in_valid  = 1'b1;
        bus.sum       = s;
        bus.operand_a = a;
        for (int i = 0; i < 500 && !done; i++) begin
            #1;
            if (bus.in_ready) begin
                sb.push_back(model(s, a));
                exp_txn++;
                if (model(s, a).err) exp_err++;
                done = 1;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 500 cycles, expected accept");
        end
    endtask

    task automatic drain_and_check_counters(input string tag);
        for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        check({tag, "_drained"}, 32'(sb.size()), 32'd0);
        check({tag, "_txn_count"}, 32'(bus.txn_count), 32'(sat16(exp_txn)));
        check({tag, "_err_count"}, 32'(bus.err_count), 32'(sat16(exp_err)));
        @(negedge clk);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.operand_a = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_operand_b", 32'(bus.operand_b), 32'd0);
        check("rst_range_err", 32'(bus.range_err), 32'd0);
        check("rst_txn_count", 32'(bus.txn_count), 32'd0);
        check("rst_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic transaction and two-edge latency
        ready_mode = 1;
        send(9'd30, 8'd10);
        #1;
        check("latency_edge1_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #1;
        check("latency_edge2_out_valid", 32'(bus.out_valid), 32'd1);
        check("basic_operand_b", 32'(bus.operand_b), 32'd20);
        check("basic_txn_count", 32'(bus.txn_count), 32'd1);
        check("basic_err_count", 32'(bus.err_count), 32'd0);
        @(negedge clk);
        drain_and_check_counters("basic");

        // Boundary sums
        send(9'h1FE, 8'd255);
        send(9'h000, 8'd0);
        send(9'h1FF, 8'd0);
        send(9'd5,   8'd10);
        drain_and_check_counters("boundary");
        check("boundary_err_count_is_2", 32'(bus.err_count), 32'd2);

        // Back-pressure: four fill the buffer, the fifth waits
        ready_mode = 0;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) send(9'(k * 10), 8'd0);
        bus.in_valid  = 1'b1;
        bus.sum       = 9'd50;
        bus.operand_a = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_head_stable", 32'(bus.operand_b), 32'd10);
        check("bp_four_accepted", 32'(bus.txn_count), 32'(exp_txn));
        @(negedge clk);
        ready_mode = 1;
        send(9'd50, 8'd0);
        drain_and_check_counters("backpressure");

        // Full buffer, then simultaneous push/pop stream
        ready_mode = 0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) send(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
        ready_mode = 1;
        for (int k = 0; k < 20; k++) send(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
        drain_and_check_counters("full_stream");

        // Random stream with random back-pressure
        ready_mode = 2;
        for (int k = 0; k < 1000; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)));
        end
        drain_and_check_counters("random");

        // Reset with three entries queued
        ready_mode = 0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) send(9'(100 + k), 8'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_txn_count", 32'(bus.txn_count), 32'd0);
        check("midrst_err_count", 32'(bus.err_count), 32'd0);
        sb.delete();
        exp_txn = 0;
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        @(negedge clk);
        send(9'd7, 8'd3);
        drain_and_check_counters("after_reset");

        // Counter saturation
        for (int k = 0; k < 65540; k++) send(9'h1FF, 8'd0);
        drain_and_check_counters("saturation");
        check("sat_txn_ffff", 32'(bus.txn_count), 32'hFFFF);
        check("sat_err_ffff", 32'(bus.err_count), 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
